// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Imported by clkdiv_period_counter and clk_divider_prog.
package clkdiv_pkg;

   localparam int unsigned CNT_W_DEFAULT = 8;

   localparam logic MODE_PULSE  = 1'b0;
   localparam logic MODE_SQUARE = 1'b1;

   // Number of high cycles in square mode: ceil(N/2).
   function automatic logic [31:0] sq_high(input logic [31:0] n);
      return (n + 32'd1) >> 1;
   endfunction

endpackage

// File: rtl/clkdiv_period_counter.sv
// Period counter for clk_divider_prog: holds count, detects the wrap point,
// and applies enable gating plus a synchronous clear used when settings change while disabled.
module clkdiv_period_counter
   import clkdiv_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic [CNT_W-1:0] n_i,
   output logic [CNT_W-1:0] count_d_o,
   output logic             wrap_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // n_i is never 0, so N-1 cannot underflow.
   assign wrap_o = (count_q == n_i - CNT_W'(1));

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = wrap_o ? '0 : count_q + CNT_W'(1);
      end
   end

   assign count_d_o = count_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider with pulse/square output and load/ack handshake.
// Define CLKDIV_STATUS_EN to expose registered status ports cur_div, cur_mode and pend.
module clk_divider_prog
   import clkdiv_pkg::*;
#(
   parameter int unsigned CNT_W        = CNT_W_DEFAULT,
   parameter int unsigned DEFAULT_DIV  = 3,
   parameter bit          DEFAULT_MODE = MODE_PULSE
) (
   input  logic             in_clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_mode,
   input  logic             div_load,
   output logic             div_ack,
   output logic             out_clk,
   output logic             out_tick
`ifdef CLKDIV_STATUS_EN
   ,
   output logic [CNT_W-1:0] cur_div,
   output logic             cur_mode,
   output logic             pend
`endif
);

   logic [CNT_W-1:0] n_q, n_d;
   logic             mode_q, mode_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             pend_mode_q, pend_mode_d;
   logic             out_clk_q, out_clk_d;
   logic             out_tick_q, out_tick_d;
   logic             ack_q, ack_d;

   logic [CNT_W-1:0] load_div;
   logic [CNT_W-1:0] eff_div;
   logic             eff_mode;
   logic             eff_valid;
   logic             apply_en;
   logic             apply_dis;
   logic [CNT_W-1:0] count_d;
   logic             wrap;
   logic [31:0]      sq_thr;

   clkdiv_period_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk_i     (in_clk),
      .rst_i     (reset),
      .enable_i  (enable),
      .clear_i   (apply_dis),
      .n_i       (n_q),
      .count_d_o (count_d),
      .wrap_o    (wrap)
   );

   assign load_div = (div_val == '0) ? CNT_W'(1) : div_val;

   // A load in the wrap cycle itself is seen here, so it applies at that same wrap.
   assign eff_valid = pend_q | div_load;
   assign eff_div   = div_load ? load_div : pend_div_q;
   assign eff_mode  = div_load ? div_mode : pend_mode_q;
   assign apply_en  = enable & wrap & eff_valid;
   assign apply_dis = ~enable & pend_q;

   always_comb begin
      pend_d      = pend_q;
      pend_div_d  = pend_div_q;
      pend_mode_d = pend_mode_q;
      n_d         = n_q;
      mode_d      = mode_q;
      if (div_load) begin
         pend_d      = 1'b1;
         pend_div_d  = load_div;
         pend_mode_d = div_mode;
      end
      if (apply_en) begin
         pend_d = 1'b0;
         n_d    = eff_div;
         mode_d = eff_mode;
      end else if (apply_dis) begin
         // A load arriving in the same cycle stays pending for the next boundary.
         pend_d = div_load;
         n_d    = pend_div_q;
         mode_d = pend_mode_q;
      end
   end

   always_comb begin
      sq_thr     = sq_high(32'(n_d));
      out_clk_d  = (mode_d == MODE_SQUARE) ? (32'(count_d) < sq_thr) : (count_d == '0);
      out_tick_d = enable & wrap;
      ack_d      = apply_en | apply_dis;
   end

   always_ff @(posedge in_clk or posedge reset) begin
      if (reset) begin
         n_q         <= CNT_W'(DEFAULT_DIV);
         mode_q      <= DEFAULT_MODE;
         pend_q      <= 1'b0;
         pend_div_q  <= CNT_W'(1);
         pend_mode_q <= MODE_PULSE;
         out_clk_q   <= 1'b1;
         out_tick_q  <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         n_q         <= n_d;
         mode_q      <= mode_d;
         pend_q      <= pend_d;
         pend_div_q  <= pend_div_d;
         pend_mode_q <= pend_mode_d;
         out_clk_q   <= out_clk_d;
         out_tick_q  <= out_tick_d;
         ack_q       <= ack_d;
      end
   end

   assign out_clk  = out_clk_q;
   assign out_tick = out_tick_q;
   assign div_ack  = ack_q;

`ifdef CLKDIV_STATUS_EN
   assign cur_div  = n_q;
   assign cur_mode = mode_q;
   assign pend     = pend_q;
`endif

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed self-checking bench for clk_divider_prog; expected {out_clk,out_tick,div_ack}
// per cycle go through a scoreboard queue and are compared one cycle later.
module tb_clk_divider_prog;

   localparam int unsigned CNT_W = 8;

   logic             in_clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [CNT_W-1:0] div_val;
   logic             div_mode;
   logic             div_load;
   logic             div_ack;
   logic             out_clk;
   logic             out_tick;
`ifdef CLKDIV_STATUS_EN
   logic [CNT_W-1:0] cur_div;
   logic             cur_mode;
   logic             pend;
`endif

   logic [2:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   always #5 in_clk = ~in_clk;

   clk_divider_prog #(
      .CNT_W        (CNT_W),
      .DEFAULT_DIV  (3),
      .DEFAULT_MODE (1'b0)
   ) dut (
      .in_clk   (in_clk),
      .reset    (reset),
      .enable   (enable),
      .div_val  (div_val),
      .div_mode (div_mode),
      .div_load (div_load),
      .div_ack  (div_ack),
      .out_clk  (out_clk),
      .out_tick (out_tick)
`ifdef CLKDIV_STATUS_EN
      ,
      .cur_div  (cur_div),
      .cur_mode (cur_mode),
      .pend     (pend)
`endif
   );

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed {clk,tick,ack}=%b expected %b", tag, obs, exp);
      end
   endtask

   // Push the expectation for the next edge, then compare once that edge has settled.
   task automatic step(input string tag, input logic [2:0] e);
      logic [2:0] x;
      exp_q.push_back(e);
      @(posedge in_clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty, observed %b", tag, {out_clk, out_tick, div_ack});
      end else begin
         x = exp_q.pop_front();
         check(tag, {out_clk, out_tick, div_ack}, x);
      end
   endtask

   task automatic run(input string tag, input logic [2:0] e, input int n);
      for (int i = 0; i < n; i++) step(tag, e);
   endtask

   task automatic load(input logic [CNT_W-1:0] v, input logic m);
      div_val  = v;
      div_mode = m;
      div_load = 1'b1;
   endtask

   initial begin
      reset    = 1'b1;
      enable   = 1'b0;
      div_val  = '0;
      div_mode = 1'b0;
      div_load = 1'b0;
      #12;
      check("reset_state", {out_clk, out_tick, div_ack}, 3'b100);
      @(posedge in_clk);
      #1;
      reset  = 1'b0;
      enable = 1'b1;

      // Defaults: divide by 3, pulse
      for (int p = 0; p < 2; p++) begin
         step("def_c1", 3'b000);
         step("def_c2", 3'b000);
         step("def_wrap", 3'b110);
      end

      // Load 5/square mid-period; old period completes first
      step("p2_c1", 3'b000);
      load(8'd5, 1'b1);
      step("p2_c2", 3'b000);
      div_load = 1'b0;
      step("p2_apply", 3'b111);
      for (int p = 0; p < 2; p++) begin
         step("sq5_c1", 3'b100);
         step("sq5_c2", 3'b100);
         step("sq5_c3", 3'b000);
         step("sq5_c4", 3'b000);
         step("sq5_wrap", 3'b110);
      end

      // Two loads before wrap: last wins, one ack
      load(8'd4, 1'b0);
      step("p3_c1", 3'b100);
      div_load = 1'b0;
      step("p3_c2", 3'b100);
      load(8'd6, 1'b1);
      step("p3_c3", 3'b000);
      div_load = 1'b0;
      step("p3_c4", 3'b000);
      step("p3_apply", 3'b111);
      step("sq6_c1", 3'b100);
      step("sq6_c2", 3'b100);
      run("sq6_low", 3'b000, 3);
      step("sq6_wrap", 3'b110);

      // Load while disabled: applied on the next edge with count forced to 0
      step("p5_c1", 3'b100);
      step("p5_c2", 3'b100);
      step("p5_c3", 3'b000);
      enable = 1'b0;
      load(8'd7, 1'b0);
      step("p5_hold", 3'b000);
      div_load = 1'b0;
      step("p5_apply_dis", 3'b101);
      step("p5_idle", 3'b100);
      enable = 1'b1;
      run("pl7_low", 3'b000, 6);
      step("pl7_wrap", 3'b110);

      // div_val=0 maps to 1: constant high, tick every cycle
      load(8'd0, 1'b0);
      step("p4_c1", 3'b000);
      div_load = 1'b0;
      run("p4_low", 3'b000, 5);
      step("p4_apply", 3'b111);
      run("n1_run", 3'b110, 3);
      enable = 1'b0;
      run("n1_frozen", 3'b100, 2);
      enable = 1'b1;
      step("n1_resume", 3'b110);
      // Load in the wrap cycle itself: bypass applies at this edge
      load(8'd1, 1'b1);
      step("n1_sq_bypass", 3'b111);
      div_load = 1'b0;
      run("n1_sq_run", 3'b110, 2);

      // Reset at count 2 of N=5 with a load pending
      load(8'd5, 1'b0);
      step("p6_apply", 3'b111);
      div_load = 1'b0;
      step("p6_c1", 3'b000);
      load(8'd9, 1'b1);
      step("p6_c2", 3'b000);
      div_load = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("p6_async_reset", {out_clk, out_tick, div_ack}, 3'b100);
      step("p6_in_reset", 3'b100);
      reset = 1'b0;
      for (int p = 0; p < 3; p++) begin
         step("p6_def_c1", 3'b000);
         step("p6_def_c2", 3'b000);
         step("p6_def_wrap", 3'b110);
      end

`ifdef CLKDIV_STATUS_EN
      checks++;
      assert ({cur_div, cur_mode, pend} === {8'd3, 1'b0, 1'b0}) else begin
         errors++;
         $error("FAIL status: observed div=%0d mode=%b pend=%b expected 3/0/0",
                cur_div, cur_mode, pend);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
